// File: rtl/pc_sequencer.sv
// Multicycle fetch/branch controller: owns the PC and sequences FETCH/EXEC through
// an instruction-memory req/ack handshake. It also resolves branches and keeps saturating statistics.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic [31:0]      pc,
  output logic             instr_valid,
  input  logic             ex_stall,
  input  logic [4:0]       br_op,
  input  logic [31:0]      rs1_val,
  input  logic [31:0]      rs2_val,
  input  logic [31:0]      br_target,
  output logic             taken,
  output logic             misalign,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_RESET = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10,
    S_TRAP  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             taken_q, taken_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             decision;
  logic             is_branch;

  always_comb begin
    decision = 1'b0;
    if (br_op[4]) begin
      decision = 1'b1;
    end else begin
      case (br_op)
        5'b01000: decision = (rs1_val == rs2_val);
        5'b01001: decision = (rs1_val != rs2_val);
        5'b01100: decision = ($signed(rs1_val) <  $signed(rs2_val));
        5'b01101: decision = ($signed(rs1_val) >= $signed(rs2_val));
        5'b01110: decision = (rs1_val <  rs2_val);
        5'b01111: decision = (rs1_val >= rs2_val);
        default:  decision = 1'b0;
      endcase
    end
  end

  assign is_branch = br_op[4] | (br_op[4:3] == 2'b01);

  // A misaligned taken target traps without retiring, so counters and pc stay put.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    taken_d = 1'b0;
    mis_d   = mis_q;
    bcnt_d  = bcnt_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: if (imem_ack) state_d = S_EXEC;
      S_EXEC: begin
        if (!ex_stall) begin
          if (decision && (br_target[1:0] != 2'b00)) begin
            state_d = S_TRAP;
            mis_d   = 1'b1;
          end else begin
            state_d = S_FETCH;
            if (is_branch && (bcnt_q != CNT_MAX)) bcnt_d = bcnt_q + CNT_W'(1);
            if (decision) begin
              pc_d    = br_target;
              taken_d = 1'b1;
              if (tcnt_q != CNT_MAX) tcnt_d = tcnt_q + CNT_W'(1);
            end else begin
              pc_d = pc_q + 32'd4;
            end
          end
        end
      end
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      taken_q <= 1'b0;
      mis_q   <= 1'b0;
      bcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
      mis_q   <= mis_d;
      bcnt_q  <= bcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Decoded straight from the state register so reset drops the request asynchronously.
  assign imem_req    = (state_q == S_FETCH);
  assign instr_valid = (state_q == S_EXEC);
  assign pc          = pc_q;
  assign taken       = taken_q;
  assign misalign    = mis_q;
  assign branch_cnt  = bcnt_q;
  assign taken_cnt   = tcnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each EXEC pushes its expected outcome, which is
// popped and compared on the first cycle after the EXEC-ending edge.
module tb_pc_sequencer;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             imem_req;
  logic             imem_ack = 1'b0;
  logic [31:0]      pc;
  logic             instr_valid;
  logic             ex_stall = 1'b0;
  logic [4:0]       br_op = 5'd0;
  logic [31:0]      rs1_val = 32'd0;
  logic [31:0]      rs2_val = 32'd0;
  logic [31:0]      br_target = 32'd0;
  logic             taken;
  logic             misalign;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;
  logic [1:0]       state;

  int nChecks = 0;
  int nErrors = 0;

  typedef struct packed {
    logic [31:0]      pc;
    logic             tk;
    logic [1:0]       st;
    logic [CNT_W-1:0] bc;
    logic [CNT_W-1:0] tc;
    logic             mis;
  } exp_t;

  exp_t expQ[$];

  logic [31:0]      mPc;
  logic [CNT_W-1:0] mBc;
  logic [CNT_W-1:0] mTc;
  logic             mMis;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack), .pc(pc),
    .instr_valid(instr_valid), .ex_stall(ex_stall), .br_op(br_op), .rs1_val(rs1_val),
    .rs2_val(rs2_val), .br_target(br_target), .taken(taken), .misalign(misalign),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic decide(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[4]) return 1'b1;
    case (op)
      5'b01000: return a == b;
      5'b01001: return a != b;
      5'b01100: return $signed(a) <  $signed(b);
      5'b01101: return $signed(a) >= $signed(b);
      5'b01110: return a <  b;
      5'b01111: return a >= b;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b0; ex_stall = 1'b0; br_op = 5'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mPc = 32'd0; mBc = '0; mTc = '0; mMis = 1'b0;
  endtask

  // Called at a negedge with the DUT in FETCH; returns at the negedge after EXEC ends.
  task automatic run_instr(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] tgt, input int ackDelay, input int stallCycles);
    exp_t e;
    exp_t got;
    logic d;
    for (int i = 0; i < ackDelay; i++) begin
      nChecks++;
      if (state !== 2'b01 || imem_req !== 1'b1 || pc !== mPc) begin
        nErrors++;
        $display("[TB] FAIL fetch_hold: state=%b req=%b pc=%h, expected state=01 req=1 pc=%h", state, imem_req, pc, mPc);
      end
      @(negedge clk);
    end
    nChecks++;
    if (state !== 2'b01 || imem_req !== 1'b1) begin
      nErrors++;
      $display("[TB] FAIL fetch_req: state=%b req=%b, expected state=01 req=1", state, imem_req);
    end
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    nChecks++;
    if (state !== 2'b10 || instr_valid !== 1'b1 || imem_req !== 1'b0 || taken !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL exec_entry: state=%b valid=%b req=%b taken=%b, expected 10 1 0 0", state, instr_valid, imem_req, taken);
    end
    br_op = op; rs1_val = a; rs2_val = b; br_target = tgt;
    ex_stall = (stallCycles > 0);
    d = decide(op, a, b);
    if (d && tgt[1:0] != 2'b00) begin
      mMis = 1'b1;
      e = '{pc: mPc, tk: 1'b0, st: 2'b11, bc: mBc, tc: mTc, mis: 1'b1};
    end else begin
      if (op[4] || op[4:3] == 2'b01) mBc = satInc(mBc);
      if (d) begin
        mPc = tgt;
        mTc = satInc(mTc);
      end else begin
        mPc = mPc + 32'd4;
      end
      e = '{pc: mPc, tk: d, st: 2'b01, bc: mBc, tc: mTc, mis: mMis};
    end
    expQ.push_back(e);
    for (int i = 0; i < stallCycles; i++) begin
      @(negedge clk);
      nChecks++;
      if (state !== 2'b10 || pc === mPc && mPc !== pc) begin
        nErrors++;
        $display("[TB] FAIL stall_hold: state=%b, expected 10", state);
      end
      if (i == stallCycles - 1) ex_stall = 1'b0;
    end
    if (stallCycles > 0) begin
      nChecks++;
      if (expQ.size() == 1 && (taken !== 1'b0 || instr_valid !== 1'b1)) begin
        nErrors++;
        $display("[TB] FAIL stall_outputs: taken=%b valid=%b, expected 0 1", taken, instr_valid);
      end
    end
    @(negedge clk);
    nChecks++;
    if (expQ.size() == 0) begin
      nErrors++;
      $display("[TB] FAIL scoreboard: queue empty, expected one entry");
    end else begin
      e = expQ.pop_front();
      got = '{pc: pc, tk: taken, st: state, bc: branch_cnt, tc: taken_cnt, mis: misalign};
      if (got !== e) begin
        nErrors++;
        $display("[TB] FAIL result op=%b: pc=%h tk=%b st=%b bc=%h tc=%h mis=%b, expected pc=%h tk=%b st=%b bc=%h tc=%h mis=%b",
                 op, got.pc, got.tk, got.st, got.bc, got.tc, got.mis, e.pc, e.tk, e.st, e.bc, e.tc, e.mis);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    nChecks++;
    if (pc !== 32'd0 || state !== 2'b00 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
        taken !== 1'b0 || misalign !== 1'b0 || branch_cnt !== '0 || taken_cnt !== '0) begin
      nErrors++;
      $display("[TB] FAIL reset_values: pc=%h st=%b req=%b val=%b tk=%b mis=%b bc=%h tc=%h, expected all zero",
               pc, state, imem_req, instr_valid, taken, misalign, branch_cnt, taken_cnt);
    end
    rst = 1'b0;
    #1;
    nChecks++;
    if (state !== 2'b00) begin
      nErrors++;
      $display("[TB] FAIL reset_hold: state=%b, expected 00", state);
    end
    @(negedge clk);
    nChecks++;
    if (state !== 2'b01 || imem_req !== 1'b1) begin
      nErrors++;
      $display("[TB] FAIL reset_to_fetch: state=%b req=%b, expected 01 1", state, imem_req);
    end
    mPc = 32'd0; mBc = '0; mTc = '0; mMis = 1'b0;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) run_instr(5'b00000, 32'd1, 32'd1, 32'h100, 0, 0);
    nChecks++;
    if (pc !== 32'd12) begin
      nErrors++;
      $display("[TB] FAIL seq_pc: pc=%h, expected 0000000c", pc);
    end
  endtask

  task automatic test_conditional();
    do_reset();
    run_instr(5'b01000, 32'd5, 32'd5, 32'h40, 0, 0);
    run_instr(5'b01100, 32'hFFFF_FFFF, 32'd1, 32'h80, 0, 0);
    run_instr(5'b01110, 32'hFFFF_FFFF, 32'd1, 32'hC0, 0, 0);
    nChecks++;
    if (pc !== 32'h84 || branch_cnt !== 4'd3 || taken_cnt !== 4'd2) begin
      nErrors++;
      $display("[TB] FAIL cond_summary: pc=%h bc=%0d tc=%0d, expected 84 3 2", pc, branch_cnt, taken_cnt);
    end
    run_instr(5'b01001, 32'd7, 32'd7, 32'h200, 0, 0);
    run_instr(5'b01101, 32'h8000_0000, 32'd3, 32'h300, 0, 0);
    run_instr(5'b01111, 32'h8000_0000, 32'd3, 32'h400, 0, 0);
    run_instr(5'b01010, 32'd1, 32'd2, 32'h500, 0, 0);
    run_instr(5'b00111, 32'd1, 32'd1, 32'h600, 0, 0);
  endtask

  task automatic test_handshake_stall();
    run_instr(5'b00000, 32'd0, 32'd0, 32'd0, 4, 3);
    run_instr(5'b11000, 32'd0, 32'd0, 32'h1000, 2, 2);
  endtask

  task automatic test_misalign();
    logic [31:0] trapPc;
    run_instr(5'b10000, 32'd0, 32'd0, 32'h102, 0, 0);
    trapPc = mPc;
    for (int i = 0; i < 5; i++) begin
      imem_ack = i[0];
      @(negedge clk);
      nChecks++;
      if (state !== 2'b11 || imem_req !== 1'b0 || instr_valid !== 1'b0 || misalign !== 1'b1 || pc !== trapPc) begin
        nErrors++;
        $display("[TB] FAIL trap_hold: st=%b req=%b val=%b mis=%b pc=%h, expected 11 0 0 1 %h",
                 state, imem_req, instr_valid, misalign, pc, trapPc);
      end
    end
    imem_ack = 1'b0;
    rst = 1'b1;
    #1;
    nChecks++;
    if (pc !== 32'd0 || state !== 2'b00 || misalign !== 1'b0 || branch_cnt !== '0 || taken_cnt !== '0) begin
      nErrors++;
      $display("[TB] FAIL trap_reset: pc=%h st=%b mis=%b bc=%h tc=%h, expected 0 00 0 0 0", pc, state, misalign, branch_cnt, taken_cnt);
    end
    do_reset();
  endtask

  task automatic test_pc_wrap();
    do_reset();
    run_instr(5'b10000, 32'd0, 32'd0, 32'hFFFF_FFFC, 0, 0);
    run_instr(5'b00000, 32'd0, 32'd0, 32'h8, 0, 0);
    nChecks++;
    if (pc !== 32'd0) begin
      nErrors++;
      $display("[TB] FAIL pc_wrap: pc=%h, expected 00000000", pc);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 18; i++) run_instr(5'b10001, 32'd0, 32'd0, 32'(i * 16 + 32'h2000), 0, 0);
    nChecks++;
    if (branch_cnt !== 4'hF || taken_cnt !== 4'hF) begin
      nErrors++;
      $display("[TB] FAIL saturation: bc=%h tc=%h, expected f f", branch_cnt, taken_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    run_instr(5'b00000, 32'd0, 32'd0, 32'd0, 0, 0);
    #2;
    rst = 1'b1;
    imem_ack = 1'b1;
    #1;
    nChecks++;
    if (imem_req !== 1'b0 || pc !== 32'd0 || state !== 2'b00) begin
      nErrors++;
      $display("[TB] FAIL async_reset: req=%b pc=%h st=%b, expected 0 0 00", imem_req, pc, state);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    nChecks++;
    if (state !== 2'b01) begin
      nErrors++;
      $display("[TB] FAIL stale_ack: state=%b, expected 01", state);
    end
    mPc = 32'd0; mBc = '0; mTc = '0; mMis = 1'b0;
    run_instr(5'b00000, 32'd0, 32'd0, 32'd0, 1, 0);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_conditional();
    test_handshake_stall();
    test_misalign();
    test_pc_wrap();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
